mul_seq_ctrl: RTL and testbench

Sequencing controller for the radix-16 Booth multiplier datapath. It accepts an operand-valid handshake and drives the operand-capture, partial-product/carry shift-register load and the per-digit iteration. It also drives the final carry-propagate step and the result-valid handshake. It sits between the multiplier's top-level request/response ports and the datapath (operand registers, Booth digit selector, pp/carry shift register, final adder).

---
 rtl/mul_pkg.sv | 15 +
 rtl/mul_seq_ctrl.sv | 114 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared sizing and state encoding for the radix-16 Booth multiplier sequencer.
package mul_pkg;

    localparam int WIDTH  = 32;
    localparam int N_ITER = WIDTH / 4;
    localparam int CNT_W  = $clog2(N_ITER);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } mul_state_e;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the radix-16 Booth datapath: capture, N_ITER digit shifts, final add, result hold.
// Accept to out_valid is N_ITER+2 cycles; out_valid holds until out_ready, abort/rst drop to IDLE.
module mul_seq_ctrl #(
    parameter int WIDTH  = mul_pkg::WIDTH,
    parameter int N_ITER = WIDTH / 4,
    parameter int CNT_W  = $clog2(N_ITER)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_signed,
    output logic             in_ready,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             op_capture,
    output logic             load,
    output logic             shift_en,
    output logic [CNT_W-1:0] digit_idx,
    output logic             final_add_en,
    output logic             op_signed,
    output logic             busy,
    output logic [15:0]      op_count
);
    import mul_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_signed_q, op_signed_d;
    logic [15:0]      op_count_q, op_count_d;

    logic abort_act;
    logic accept;

    // Abort only matters once an operation is in flight; in IDLE it is ignored.
    assign abort_act = abort && (state_q != IDLE);
    assign in_ready  = !abort_act &&
                       ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_signed_d = op_signed_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = CALC;
                    cnt_d       = '0;
                    op_signed_d = in_signed;
                end
            end
            CALC: begin
                if (abort_act) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FINAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINAL: begin
                state_d = abort_act ? IDLE : DONE;
            end
            DONE: begin
                if (abort_act) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    // Back-to-back: a new operation starts in the same cycle the result leaves.
                    if (accept) begin
                        state_d     = CALC;
                        cnt_d       = '0;
                        op_signed_d = in_signed;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_signed_q <= 1'b0;
            op_count_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_signed_q <= op_signed_d;
            op_count_q  <= op_count_d;
        end
    end

    assign op_capture   = accept;
    assign load         = accept;
    assign shift_en     = (state_q == CALC);
    assign digit_idx    = (state_q == CALC) ? cnt_q : '0;
    assign final_add_en = (state_q == FINAL);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign op_signed    = op_signed_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl at the default WIDTH=32 (8 digits, 10 cycles accept to valid).
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_signed;
    logic        in_ready;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic        op_capture;
    logic        load;
    logic        shift_en;
    logic [2:0]  digit_idx;
    logic        final_add_en;
    logic        op_signed;
    logic        busy;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;

    mul_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_signed    (in_signed),
        .in_ready     (in_ready),
        .abort        (abort),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .op_capture   (op_capture),
        .load         (load),
        .shift_en     (shift_en),
        .digit_idx    (digit_idx),
        .final_add_en (final_add_en),
        .op_signed    (op_signed),
        .busy         (busy),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int accepts;
        int idle_seen;
        int valid_seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        check("rst_strobes", {load, op_capture, shift_en, final_add_en}, 0);
        check("rst_op_signed", op_signed, 0);
        check("rst_digit_idx", digit_idx, 0);

        // Single unsigned operation: accept-cycle strobes, 8 digits, final add, valid at +10
        next_cycle();
        in_valid = 1'b1;
        #1;
        check("acc_load_capture", {load, op_capture}, 2'b11);
        check("acc_shift_en", shift_en, 0);
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("calc_shift_en", shift_en, 1);
            check("calc_digit_idx", digit_idx, i);
            check("calc_excl", {load, final_add_en, out_valid}, 0);
            check("calc_op_signed", op_signed, 0);
            next_cycle();
        end
        #1;
        check("final_add_en", final_add_en, 1);
        check("final_excl", {shift_en, load, out_valid}, 0);
        check("final_digit_idx", digit_idx, 0);
        next_cycle();

        // Backpressure: result held while out_ready is low
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_op_count", op_count, 0);
            check("bp_shift_en", shift_en, 0);
            next_cycle();
        end
        out_ready = 1'b1;
        #1;
        check("drain_in_ready", in_ready, 1);
        next_cycle();
        out_ready = 1'b0;
        #1;
        check("drain_out_valid", out_valid, 0);
        check("drain_busy", busy, 0);
        check("drain_op_count", op_count, 1);

        // Back-to-back: accepts every 10 cycles, never idle in between
        next_cycle();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        accepts   = 0;
        idle_seen = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            check("b2b_accept", load, (c % 10 == 0) ? 1 : 0);
            if (load) accepts++;
            if (c > 0 && !busy) idle_seen++;
            next_cycle();
        end
        in_valid = 1'b0;
        #1;
        check("b2b_accepts", accepts, 3);
        check("b2b_no_idle", idle_seen, 0);
        check("b2b_last_valid", out_valid, 1);
        next_cycle();
        out_ready = 1'b0;
        #1;
        check("b2b_op_count", op_count, 4);
        check("b2b_idle", busy, 0);

        // Abort in CALC at digit 3
        next_cycle();
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();
        abort = 1'b1;
        #1;
        check("abort_digit_idx", digit_idx, 3);
        check("abort_in_ready", in_ready, 0);
        next_cycle();
        abort = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready_after", in_ready, 1);
        valid_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) valid_seen++;
            next_cycle();
        end
        check("abort_no_valid", valid_seen, 0);
        check("abort_op_count", op_count, 4);

        // Abort colliding with out_ready and in_valid in DONE
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) next_cycle();
        abort     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        check("abort_done_valid", out_valid, 1);
        check("abort_done_no_accept", load, 0);
        next_cycle();
        abort     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("abort_done_busy", busy, 0);
        check("abort_done_op_count", op_count, 4);

        // Abort in IDLE is ignored
        next_cycle();
        abort    = 1'b1;
        in_valid = 1'b1;
        #1;
        check("abort_idle_in_ready", in_ready, 1);
        check("abort_idle_load", load, 1);
        next_cycle();
        in_valid = 1'b0;
        #1;
        check("abort_idle_started", shift_en, 1);
        next_cycle();
        abort = 1'b0;
        #1;
        check("abort_calc2_busy", busy, 0);

        // Synchronous reset at FINAL
        next_cycle();
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) next_cycle();
        #1;
        check("rstf_final", final_add_en, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("rstf_busy", busy, 0);
        check("rstf_op_count", op_count, 0);
        valid_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) valid_seen++;
            next_cycle();
        end
        check("rstf_no_valid", valid_seen, 0);

        // Reset pulse confined to the clock-low phase is not sampled
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        #1;
        check("glitch_digit0", digit_idx, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        next_cycle();
        #1;
        check("glitch_busy", busy, 1);
        check("glitch_digit1", digit_idx, 1);
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;

        // Signed mode held through the operation; op_count wraps 0xFFFF -> 0
        next_cycle();
        in_valid  = 1'b1;
        in_signed = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        for (int i = 0; i < 8; i++) begin
            in_signed = (i % 2 == 0) ? 1'b0 : 1'b1;
            #1;
            check("sgn_calc", op_signed, 1);
            next_cycle();
        end
        #1;
        check("sgn_final", op_signed, 1);
        next_cycle();
        out_ready = 1'b1;
        #1;
        check("sgn_done", op_signed, 1);
        check("wrap_pre_valid", out_valid, 1);
        next_cycle();
        out_ready = 1'b0;
        #1;
        check("wrap_op_count", op_count, 0);
        check("wrap_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
